// File: rtl/pc_table_pkg.sv
// pc_table_pkg: loader state encoding, stream end marker and preload image for pc_target_table
package pc_table_pkg;
  typedef enum logic [1:0] {IDLE, GET_IDX, GET_LO, GET_HI} ld_state_e;
  localparam logic [7:0] END_MARK = 8'hFF;
  localparam int PRELOAD_COUNT = 8;
  localparam logic [PRELOAD_COUNT-1:0][15:0] PRELOAD = {
    16'd132, 16'd59, 16'd117, 16'd7, 16'd7, 16'd1, 16'd20, 16'd13
  };
endpackage

// File: rtl/pc_table_loader.sv
// pc_table_loader: byte-stream loader FSM assembling {index, lo, hi} records into commit strobes
// PC_TARGET_PRELOAD_EN makes table_ready come out of reset high
module pc_table_loader
  import pc_table_pkg::*;
#(
  parameter int D     = 12,
  parameter int AW    = 5,
  parameter int DEPTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [7:0]    ld_byte,
  output logic          ld_ready,
  output logic          table_ready,
  output logic          ld_err,
  output logic          clear,
  output logic          commit,
  output logic [AW-1:0] commit_idx,
  output logic [D-1:0]  commit_data
);
  ld_state_e state_q, state_d;
  logic [7:0] idx_q, idx_d, lo_q, lo_d;
  logic       err_q, err_d, rdy_q, rdy_d;
  logic       accept, in_range;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      lo_q    <= '0;
      err_q   <= 1'b0;
`ifdef PC_TARGET_PRELOAD_EN
      rdy_q   <= 1'b1;
`else
      rdy_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      lo_q    <= lo_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end
  // ld_start wins over any byte arriving in the same cycle
  always_comb begin
    state_d = ld_start ? GET_IDX :
              !accept ? state_q :
              (state_q == GET_IDX && ld_byte == END_MARK) ? IDLE :
              (state_q == GET_HI) ? GET_IDX : ld_state_e'(state_q + 2'd1);
  end
  always_comb begin
    ld_ready    = state_q != IDLE;
    accept      = ld_valid && ld_ready && !ld_start;
    in_range    = 32'(idx_q) < DEPTH;
    clear       = ld_start;
    commit      = accept && state_q == GET_HI && in_range;
    commit_idx  = idx_q[AW-1:0];
    commit_data = {ld_byte[D-9:0], lo_q};
    table_ready = rdy_q;
    ld_err      = err_q;
  end
  always_comb begin
    idx_d = (accept && state_q == GET_IDX) ? ld_byte : idx_q;
    lo_d  = (accept && state_q == GET_LO) ? ld_byte : lo_q;
    err_d = ld_start ? 1'b0 : (accept && state_q == GET_HI && !in_range) ? 1'b1 : err_q;
    rdy_d = ld_start ? 1'b0 : (accept && state_q == GET_IDX && ld_byte == END_MARK) ? 1'b1 : rdy_q;
  end
endmodule

// File: rtl/pc_target_table.sv
// pc_target_table: runtime-loadable branch-target table with registered lookup and write-through bypass
// PC_TARGET_PRELOAD_EN resets entries 0..7 to a fixed valid image
module pc_target_table
  import pc_table_pkg::*;
#(
  parameter int             D              = 12,
  parameter int             AW             = 5,
  parameter int             DEPTH          = 32,
  parameter logic [D-1:0]   DEFAULT_TARGET = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_start,
  input  logic          ld_valid,
  input  logic [7:0]    ld_byte,
  output logic          ld_ready,
  output logic          table_ready,
  output logic          ld_err,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [D-1:0]  target,
  output logic          rd_valid,
  output logic          rd_miss
);
  localparam int N = 1 << AW;
  logic          clear, commit, byp, hit;
  logic [AW-1:0] commit_idx;
  logic [D-1:0]  commit_data;
  logic [D-1:0]  mem_q [N];
  logic [D-1:0]  mem_d [N];
  logic [N-1:0]  valid_q, valid_d;
  logic [D-1:0]  target_q, target_d;
  logic          rd_valid_q, rd_valid_d, rd_miss_q, rd_miss_d;
  pc_table_loader #(.D(D), .AW(AW), .DEPTH(DEPTH)) u_loader (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld_start    (ld_start),
    .ld_valid    (ld_valid),
    .ld_byte     (ld_byte),
    .ld_ready    (ld_ready),
    .table_ready (table_ready),
    .ld_err      (ld_err),
    .clear       (clear),
    .commit      (commit),
    .commit_idx  (commit_idx),
    .commit_data (commit_data)
  );
  // Entries at or above DEPTH are never written, so their valid bits stay 0 and read as misses
  always_comb begin
    mem_d   = mem_q;
    valid_d = clear ? '0 : valid_q;
    if (commit) begin
      mem_d[commit_idx]   = commit_data;
      valid_d[commit_idx] = 1'b1;
    end
  end
  always_comb begin
    byp        = commit && commit_idx == rd_addr;
    hit        = !clear && (byp || valid_q[rd_addr]);
    rd_valid_d = rd_en;
    target_d   = !rd_en ? target_q : byp ? commit_data : hit ? mem_q[rd_addr] : DEFAULT_TARGET;
    rd_miss_d  = rd_en ? !hit : rd_miss_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mem_q[i] <= '0;
      valid_q <= '0;
`ifdef PC_TARGET_PRELOAD_EN
      for (int i = 0; i < PRELOAD_COUNT; i++) begin
        mem_q[i]   <= PRELOAD[i][D-1:0];
        valid_q[i] <= 1'b1;
      end
`endif
      target_q   <= DEFAULT_TARGET;
      rd_valid_q <= 1'b0;
      rd_miss_q  <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      valid_q    <= valid_d;
      target_q   <= target_d;
      rd_valid_q <= rd_valid_d;
      rd_miss_q  <= rd_miss_d;
    end
  end
  assign target   = target_q;
  assign rd_valid = rd_valid_q;
  assign rd_miss  = rd_miss_q;
endmodule

// File: tb/tb_pc_target_table.sv
// tb_pc_target_table: directed plus randomized stream/lookup checks against a record-level table model
module tb_pc_target_table;
  localparam int D = 12, AW = 5, DEPTH = 32;
  logic clk = 0, rst_n = 0, ld_start = 0, ld_valid = 0, rd_en = 0;
  logic [7:0] ld_byte = 0;
  logic [AW-1:0] rd_addr = 0;
  logic ld_ready, table_ready, ld_err, rd_valid, rd_miss;
  logic [D-1:0] target;
  int npass = 0, ntot = 0, nfail = 0;
  int mtab[DEPTH];
  bit mval[DEPTH];
  int phase, pidx, plo, etgt;
  bit mrdy, merr, emiss, evld;
  int pre[8] = '{13, 20, 1, 7, 7, 117, 59, 132};

  pc_target_table dut (
    .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte),
    .ld_ready(ld_ready), .table_ready(table_ready), .ld_err(ld_err), .rd_en(rd_en),
    .rd_addr(rd_addr), .target(target), .rd_valid(rd_valid), .rd_miss(rd_miss)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic mreset();
    for (int i = 0; i < DEPTH; i++) begin mval[i] = 0; mtab[i] = 0; end
    mrdy = 0;
`ifdef PC_TARGET_PRELOAD_EN
    for (int i = 0; i < 8; i++) begin mval[i] = 1; mtab[i] = pre[i]; end
    mrdy = 1;
`endif
    phase = 0; merr = 0; etgt = 0; emiss = 0; evld = 0;
  endtask

  task automatic check_all(string tag);
    chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(evld));
    chk({tag, ".target"}, 32'(target), etgt);
    chk({tag, ".rd_miss"}, 32'(rd_miss), 32'(emiss));
    chk({tag, ".ld_ready"}, 32'(ld_ready), 32'(phase != 0));
    chk({tag, ".table_ready"}, 32'(table_ready), 32'(mrdy));
    chk({tag, ".ld_err"}, 32'(ld_err), 32'(merr));
  endtask

  // One clock: record-level model of what the loader accepts and what a lookup must return
  task automatic cyc(string tag, bit s, bit v, int b, bit re, int ra);
    bit hit;
    int val, newv;
    @(negedge clk);
    ld_start = s; ld_valid = v; ld_byte = 8'(b); rd_en = re; rd_addr = AW'(ra);
    @(posedge clk);
    newv = (b % (1 << (D - 8))) * 256 + plo;
    evld = re;
    if (re) begin
      hit = 0; val = 0;
      if (!s && phase == 3 && v && pidx < DEPTH && pidx == ra) begin hit = 1; val = newv; end
      else if (!s && ra < DEPTH && mval[ra]) begin hit = 1; val = mtab[ra]; end
      etgt = hit ? val : 0;
      emiss = !hit;
    end
    if (s) begin
      for (int i = 0; i < DEPTH; i++) mval[i] = 0;
      merr = 0; mrdy = 0; phase = 1;
    end else if (v && phase != 0) begin
      if (phase == 1) begin
        if (b == 255) begin mrdy = 1; phase = 0; end
        else begin pidx = b; phase = 2; end
      end else if (phase == 2) begin
        plo = b; phase = 3;
      end else begin
        if (pidx < DEPTH) begin mtab[pidx] = newv; mval[pidx] = 1; end
        else merr = 1;
        phase = 1;
      end
    end
    #1 check_all(tag);
  endtask

  task automatic send(string tag, int b); cyc(tag, 0, 1, b, 0, 0); endtask
  task automatic look(string tag, int a); cyc(tag, 0, 0, 0, 1, a); endtask
  task automatic start(string tag); cyc(tag, 1, 0, 0, 0, 0); endtask

  initial begin
    int s, v, b, re;
    mreset();
    plo = 0; pidx = 0;
    #12 check_all("reset");
    @(negedge clk) rst_n = 1;
    look("rst_lookup3", 3);

    start("basic_start");
    foreach (pre[i]) if (i < 0) send("never", 0);
    send("b0", 8'h02); send("b1", 8'h75); send("b2", 8'h00);
    send("b3", 8'h05); send("b4", 8'h3B); send("b5", 8'h00);
    send("b6", 8'h1F); send("b7", 8'h84); send("b8", 8'h00);
    send("b_end", 8'hFF);
    look("basic_l2", 2); look("basic_l5", 5); look("basic_l31", 31); look("basic_l4", 4);

    start("oor_start");
    send("o0", 8'h20); send("o1", 8'h11); send("o2", 8'h01);
    send("o3", 8'h00); send("o4", 8'h0D); send("o5", 8'h00);
    send("o_end", 8'hFF);
    look("oor_l0", 0); look("oor_l1", 1);

    start("ovw_start");
    send("w0", 8'h07); send("w1", 8'hAB); send("w2", 8'h0F);
    send("w3", 8'h07); send("w4", 8'h01); send("w5", 8'h00);
    send("w6", 8'h06); send("w7", 8'hFF); send("w8", 8'hFF);
    send("w_end", 8'hFF);
    look("ovw_l7", 7); look("mask_l6", 6);

    start("rs_start");
    send("r0", 8'h03); send("r1", 8'h22);
    start("rs_restart");
    look("rs_l3", 3); look("rs_l7", 7);

    send("m0", 8'h04); send("m1", 8'h33);
    @(negedge clk) rst_n = 0;
    #2 mreset();
    check_all("mid_reset");
    @(negedge clk) rst_n = 1;
    look("mid_reset_l4", 4);

    start("col_start");
    send("c0", 8'h09); send("c1", 8'hA8);
    cyc("col_bypass", 0, 1, 8'h02, 1, 9);
    cyc("col_start_lookup", 1, 0, 0, 1, 9);

    for (int n = 0; n < 1500; n++) begin
      s = ($urandom % 100 == 0 || (phase == 0 && $urandom % 5 == 0)) ? 1 : 0;
      v = ($urandom % 4 != 0) ? 1 : 0;
      b = (phase == 1) ? (($urandom % 10 == 0) ? 255 : int'($urandom_range(0, 40))) : int'($urandom % 256);
      re = $urandom % 2;
      cyc("rand", s[0], v[0], b, re[0], int'($urandom % 32));
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/pc_target_table.md
Name: pc_target_table

Overview:
- Runtime-loadable branch-target table. Maps a branch-target index from the instruction to an absolute PC target.
- Storage is registered, with per-entry valid bits and one-cycle registered lookup. A serial byte-stream loader FSM fills the table, so a new program's targets load without re-synthesis.
- Sits between the instruction decoder (lookup side) and the program/test loader (byte-stream side). Feeds the PC-update mux.

Parameters:
- D, 12, target width in bits; legal range 9..16.
- AW, 5, lookup index width.
- DEPTH, 32, number of entries; must be <= 2**AW.
- DEFAULT_TARGET, 0, target returned on a miss.

Ports:
- Clk  in  1  clock, rising edge.
- Rst_n  in  1  asynchronous active-low reset.
- ld_start  in  1  one-cycle pulse: invalidate all entries and begin a load.
- ld_valid  in  1  ld_byte is valid this cycle.
- ld_byte  in  8  loader stream byte.
- ld_ready  out  1  loader accepts a byte when ld_valid && ld_ready.
- table_ready  out  1  a load has completed and the table is stable.
- ld_err  out  1  sticky: an out-of-range index was received during the current load.
- rd_en  in  1  lookup request.
- rd_addr  in  AW  lookup index.
- target  out  D  looked-up PC target.
- rd_valid  out  1  target/rd_miss are valid; asserted the cycle after rd_en.
- rd_miss  out  1  entry was invalid or rd_addr >= DEPTH.

Behaviour:
- Reset (async, Rst_n low):
  - all valid bits 0; FSM in IDLE.
  - ld_ready=0, table_ready=0, ld_err=0.
  - target=DEFAULT_TARGET, rd_valid=0, rd_miss=0.
  - Reset mid-load aborts the load immediately; no partial entry is committed.
- FSM states: IDLE, GET_IDX, GET_LO, GET_HI.
  - IDLE: ld_ready=0. On ld_start, clear all valid bits and ld_err, drop table_ready, go to GET_IDX.
  - GET_IDX: ld_ready=1. On a byte equal to END_MARK 8'hFF, set table_ready=1 and go to IDLE. Otherwise latch the index and go to GET_LO.
  - GET_LO: ld_ready=1. Latch ld_byte as target[7:0]; go to GET_HI.
  - GET_HI: ld_ready=1. Take target[D-1:8] from ld_byte[D-9:0]; upper bits are ignored.
    - Index < DEPTH: commit target and set valid, same edge.
    - Index >= DEPTH: discard the entry and set ld_err.
    - Either case: go to GET_IDX.
  - ld_start in a non-IDLE state restarts: clear valid bits and ld_err, go to GET_IDX. Any partially assembled entry is dropped.
  - ld_valid with ld_ready=0 is ignored.
  - A duplicate index overwrites the earlier entry (last write wins).
- Lookup:
  - Latency 1: rd_en sampled at edge N; target, rd_valid and rd_miss are updated at edge N.
  - Hit: target = stored value, rd_miss=0.
  - Miss (invalid entry or rd_addr >= DEPTH): target=DEFAULT_TARGET, rd_miss=1.
  - rd_en=0: rd_valid=0; target and rd_miss hold their previous values.
  - Lookups are permitted during a load and are not blocked by table_ready.
  - Same-cycle commit and lookup to the same index: lookup returns the NEW value (write-through bypass), rd_miss=0.
  - Lookup in the ld_start cycle: returns a miss (the clear takes priority).
- Width rule: stored targets are exactly D bits, zero-extended from the two bytes.

Optional Feature:
- PC_TARGET_PRELOAD_EN defined:
  - Reset loads entries 0..7 = 13, 20, 1, 7, 7, 117, 59, 132, all valid; table_ready=1 out of reset.
  - ld_start still clears the table as normal.
- Not defined: the table resets all-invalid and table_ready=0.

Decomposition:
- Package pc_table_pkg:
  - loader state enum (IDLE, GET_IDX, GET_LO, GET_HI);
  - END_MARK = 8'hFF;
  - preload constant array (8 x 16 bits) and PRELOAD_COUNT = 8.
- Sub-module pc_table_loader: the FSM, byte assembly, ld_ready, ld_err and table_ready. Outputs a commit strobe, commit index, commit data and a clear strobe.
- The top module holds the storage array, valid bits, lookup register and bypass.

Test Plan:
- Reset and table_ready:
  - Reset, then rd_en with rd_addr=3 → next cycle rd_valid=1, rd_miss=1, target=0; table_ready=0.
  - With PC_TARGET_PRELOAD_EN: the same lookup gives target=7, rd_miss=0, and table_ready=1 out of reset.
- Basic load and lookup:
  - ld_start, then stream 02,75,00, 05,3B,00, 1F,84,00, FF.
  - Expect table_ready=1 after FF, and lookups 2→117, 5→59, 31→132 with rd_miss=0.
  - Lookup 4 → miss, target=0.
- Out-of-range index:
  - Load index 0x20 (DEPTH=32) with data 11,01 → ld_err=1, no entry written.
  - A following valid entry 00,0D,00 still commits and index 0 returns 13.
- Byte assembly and overwrite:
  - Load index 7 = AB,0F, then index 7 = 01,00 → lookup 7 returns 1.
  - High-byte masking with D=12: index 6 = FF,FF returns 12'hFFF.
- Restart and reset mid-load:
  - ld_start after GET_LO of an entry → the entry is dropped and all entries read as misses.
  - Rst_n low during GET_HI → FSM in IDLE, ld_ready=0, nothing committed.
- Write/read collision:
  - Lookup index 9 in the same cycle its GET_HI byte commits 0x2A8 → rd_valid=1, target=0x2A8, rd_miss=0.
  - Lookup in the ld_start cycle → miss.
